// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared funct3 width codes and LSU state encoding
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request and data-memory signal bundle of the LSU
interface lsu_if #(
  parameter int ADDR_W = 6
);

  logic              req_valid;
  logic              req_read;
  logic              req_write;
  logic [2:0]        funct3;
  logic [ADDR_W+1:0] byte_addr;
  logic [31:0]       wdata;
  logic              busy;
  logic [31:0]       rdata;
  logic              rdata_valid;
  logic              err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // LSU side
  modport slave (
    input  req_valid, req_read, req_write, funct3, byte_addr, wdata, mem_rdata,
    output busy, rdata, rdata_valid, err, mem_read, mem_write, mem_addr, mem_wdata
  );

  // pipeline + memory side
  modport master (
    output req_valid, req_read, req_write, funct3, byte_addr, wdata, mem_rdata,
    input  busy, rdata, rdata_valid, err, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/halfword lane extract-extend for loads and merge for stores
module lsu_align
  import mem_pkg::*;
(
  input  logic [31:0] i_ld_word,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_off,
  output logic [31:0] o_ld_data,
  input  logic [31:0] i_st_word,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_off,
  output logic [31:0] o_st_word
);

  logic [31:0] w_shifted;

  // bring the addressed lane down to bit 0 before extension
  assign w_shifted = i_ld_word >> {i_ld_off, 3'b000};

  // load: sign- or zero-extend the selected lane
  always_comb begin
    o_ld_data = w_shifted;
    case (i_ld_f3)
      F3_B:    o_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_BU:   o_ld_data = {24'h0, w_shifted[7:0]};
      F3_HU:   o_ld_data = {16'h0, w_shifted[15:0]};
      default: o_ld_data = w_shifted;
    endcase
  end

  // store: replace only the addressed lane of the old word
  always_comb begin
    o_st_word = i_st_word;
    case (i_st_f3)
      F3_B:    o_st_word[{i_st_off, 3'b000} +: 8]        = i_st_data[7:0];
      F3_H:    o_st_word[{i_st_off[1], 4'b0000} +: 16]  = i_st_data[15:0];
      default: o_st_word = i_st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with read-modify-write for sub-word stores
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic [31:0]       r_rdata;
  logic              r_rdata_valid;
  logic              r_err;
  logic [31:0]       r_hold_word;
  logic [31:0]       r_hold_wdata;
  logic [2:0]        r_hold_f3;
  logic [ADDR_W+1:0] r_hold_addr;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_f3_ok;
  logic        w_aligned;
  logic        w_legal;
  logic        w_accept;
  logic        w_acc_load;
  logic        w_acc_sw;
  logic        w_acc_sub;
  logic [31:0] w_ld_data;
  logic [31:0] w_merged;

  assign w_is_load  = bus.req_read & ~bus.req_write;
  assign w_is_store = bus.req_write & ~bus.req_read;

  // funct3 must be a known width code for the kind of access
  always_comb begin
    w_f3_ok = 1'b0;
    if (w_is_load) begin
      w_f3_ok = (bus.funct3 == F3_B) || (bus.funct3 == F3_H) || (bus.funct3 == F3_W) ||
                (bus.funct3 == F3_BU) || (bus.funct3 == F3_HU);
    end else if (w_is_store) begin
      w_f3_ok = (bus.funct3 == F3_B) || (bus.funct3 == F3_H) || (bus.funct3 == F3_W);
    end
  end

  // natural alignment: halfwords on even bytes, words on word boundaries
  always_comb begin
    case (bus.funct3[1:0])
      2'b01:   w_aligned = ~bus.byte_addr[0];
      2'b10:   w_aligned = (bus.byte_addr[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  assign w_legal    = (w_is_load | w_is_store) & w_f3_ok & w_aligned;
  assign w_accept   = bus.req_valid & (r_state == ST_IDLE) & ~rst;
  assign w_acc_load = w_accept & w_legal & w_is_load;
  assign w_acc_sw   = w_accept & w_legal & w_is_store & (bus.funct3 == F3_W);
  assign w_acc_sub  = w_accept & w_legal & w_is_store & (bus.funct3 != F3_W);

  lsu_align u_align (
    .i_ld_word (bus.mem_rdata),
    .i_ld_f3   (bus.funct3),
    .i_ld_off  (bus.byte_addr[1:0]),
    .o_ld_data (w_ld_data),
    .i_st_word (r_hold_word),
    .i_st_data (r_hold_wdata),
    .i_st_f3   (r_hold_f3),
    .i_st_off  (r_hold_addr[1:0]),
    .o_st_word (w_merged)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // next state: sub-word store spends exactly one cycle in RMW
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_acc_sub) w_next_state = ST_RMW;
      ST_RMW:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // outputs: memory strobes are gated by reset so an aborted RMW never writes
  always_comb begin
    bus.busy        = (r_state == ST_RMW);
    bus.mem_read    = w_acc_load | w_acc_sub;
    bus.mem_write   = ((r_state == ST_RMW) & ~rst) | w_acc_sw;
    bus.mem_addr    = bus.byte_addr[ADDR_W+1:2];
    bus.mem_wdata   = bus.wdata;
    if (r_state == ST_RMW) begin
      bus.mem_addr  = r_hold_addr[ADDR_W+1:2];
      bus.mem_wdata = w_merged;
    end
    bus.rdata       = r_rdata;
    bus.rdata_valid = r_rdata_valid;
    bus.err         = r_err;
  end

  // load result, status pulses and RMW hold registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata       <= 32'h0;
      r_rdata_valid <= 1'b0;
      r_err         <= 1'b0;
      r_hold_word   <= 32'h0;
      r_hold_wdata  <= 32'h0;
      r_hold_f3     <= 3'b000;
      r_hold_addr   <= '0;
    end else begin
      r_rdata_valid <= w_acc_load;
      r_err         <= w_accept & ~w_legal;
      if (w_acc_load) r_rdata <= w_ld_data;
      if (w_acc_sub) begin
        r_hold_word  <= bus.mem_rdata;
        r_hold_wdata <= bus.wdata;
        r_hold_f3    <= bus.funct3;
        r_hold_addr  <= bus.byte_addr;
      end
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 6, word-address width toward data memory (64 words).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  1  access request from MEM stage.
REQ-005 req_read  in  1  load request.
REQ-006 req_write  in  1  store request.
REQ-007 funct3  in  3  RV32I width/sign code.
REQ-008 byte_addr  in  ADDR_W+2  byte address.
REQ-009 wdata  in  32  store data, right-aligned.
REQ-010 busy  out  1  unit cannot accept a request this cycle; pipeline holds.
REQ-011 rdata  out  32  load result, extended.
REQ-012 rdata_valid  out  1  rdata valid, one-cycle pulse.
REQ-013 err  out  1  misaligned or illegal request, one-cycle pulse.
REQ-014 mem_read  out  1  data-memory read enable.
REQ-015 mem_write  out  1  data-memory write enable.
REQ-016 mem_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2].
REQ-017 mem_wdata  out  32  full word to memory.
REQ-018 mem_rdata  in  32  combinational word read from memory.

Function
REQ-019 A request SHALL be accepted when req_valid=1 and busy=0; otherwise it SHALL be ignored.
REQ-020 States SHALL be IDLE and RMW; busy SHALL be 1 exactly when the state is RMW.
REQ-021 Legal funct3 values: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
REQ-022 An accepted request SHALL be illegal when:
- req_read and req_write are both 1 or both 0;
- funct3 is not legal for the access;
- it is a halfword access with byte_addr[0]=1;
- it is a word access with byte_addr[1:0]≠00.
REQ-023 Illegal request: no mem_read or mem_write; err=1 on the following cycle; state unchanged.
REQ-024 Load: mem_read=1 in the accept cycle. The selected byte/halfword from byte_addr[1:0] SHALL be sign-extended (LB/LH) or zero-extended (LBU/LHU) and registered into rdata. rdata_valid=1 on the next cycle (latency 1).
REQ-025 SW: mem_write=1 and mem_wdata=wdata in the accept cycle; state stays IDLE.
REQ-026 SB/SH accept cycle: mem_read=1 and mem_write=0; capture mem_rdata, wdata, funct3 and byte_addr into hold registers; go to RMW.
REQ-027 RMW cycle:
- mem_write=1 at the held word address;
- mem_wdata = held word with only the addressed byte/halfword lane replaced by wdata[7:0]/[15:0];
- return to IDLE; next request accepted the following cycle.
REQ-028 rdata SHALL hold its last value between loads; rdata_valid and err SHALL never be 1 in the same cycle.
REQ-029 mem_read and mem_write SHALL never be 1 in the same cycle; both SHALL be 0 when no access is in progress.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE and rdata=0, rdata_valid=0, err=0, and clear the hold registers.
REQ-031 With rst=1, mem_write and mem_read SHALL be 0 combinationally. A reset arriving in RMW SHALL abort the write, leaving memory unmodified.

Structure
REQ-032 Shared package mem_pkg SHALL hold the funct3 width constants and the state enumeration.
REQ-033 Lane logic SHALL be one combinational sub-module, lsu_align, containing the load extract/extend and the store merge; the FSM and registers stay in load_store_unit.

Verification
REQ-034 Memory word 0=0x8000_F011, LB at byte 0 → rdata 0x0000_0011 one cycle later, rdata_valid pulse. LB at byte 3 → 0xFFFF_FF80.
REQ-035 Word 1=0x0000_0009, SH wdata 0xABCD at byte 6:
- accept cycle: busy=0, mem_read=1;
- next cycle: busy=1, mem_write=1, mem_wdata=0xABCD_0009.
- Memory then word 1=0xABCD_0009.
REQ-036 LW at byte 5 → err pulse, no mem_read/mem_write, rdata unchanged. req_read=req_write=1 → err.
REQ-037 Word 2=0x0000_0019, SB 0x7F at byte 9; rst=1 during the RMW cycle → mem_write=0, word 2 stays 0x0000_0019, busy=0 after reset.
REQ-038 Back-to-back SB then LBU on the same byte: second request held while busy. LBU accepted the cycle after RMW, returning 0x0000_007F.
